csa_carry_resolve: RTL and testbench

//  Carry-propagate stage placed directly after the carry-save adder. Takes one

---
 rtl/csa_pkg.sv | 13 +
 rtl/cpa_chunk.sv | 24 ++
 rtl/csa_carry_resolve.sv | 163 ++++++++++++++++
 tb/tb_csa_carry_resolve.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csa_pkg.sv
// Shared types and default sizing for the CSA carry-resolve stage.
package csa_pkg;

    localparam int unsigned CSA_W_DEF     = 8;
    localparam int unsigned CSA_CHUNK_DEF = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } csa_state_e;

endpackage

// File: rtl/cpa_chunk.sv
// N-bit ripple-carry adder built from a chain of full adders.
module cpa_chunk #(
    parameter int unsigned N = 2
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    logic [N:0] c;

    assign c[0] = cin;

    // One full adder per bit, carry rippling upward.
    for (genvar i = 0; i < N; i++) begin : g_fa
        assign s[i]     = a[i] ^ b[i] ^ c[i];
        assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign cout = c[N];

endmodule

// File: rtl/csa_carry_resolve.sv
// Resolves a carry-save {sum, carry} pair to binary, CHUNK bits per cycle.
// Optional feature macro: CSA_RESOLVE_OVF_EN adds the out_ovf flag
// (result >= 2^W); without it the port and its register are not built.
module csa_carry_resolve
    import csa_pkg::*;
#(
    parameter int unsigned W     = CSA_W_DEF,
    parameter int unsigned CHUNK = CSA_CHUNK_DEF
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [W-1:0]   sum_in,
    input  logic [W-1:0]   carry_in,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [W+1:0]   result
`ifdef CSA_RESOLVE_OVF_EN
    ,
    output logic           out_ovf
`endif
);

    localparam int unsigned NCH = W / CHUNK;
    localparam int unsigned CW  = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int unsigned RW  = W + 2;
    localparam logic [RW-1:0] CHUNK_MASK = RW'({CHUNK{1'b1}});

    // Reject widths that do not split into whole chunks.
    if ((W % CHUNK) != 0) begin : g_chunk_check
        $error("csa_carry_resolve: CHUNK must divide W");
    end

    csa_state_e     state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           cy_q, cy_d;
    logic [W-1:0]   opx_q, opx_d;
    logic [W-1:0]   opy_q, opy_d;
    logic [RW-1:0]  result_q, result_d;
    logic           in_ready_q, in_ready_d;
    logic           out_valid_q, out_valid_d;

    logic [CHUNK-1:0] chunk_a;
    logic [CHUNK-1:0] chunk_b;
    logic [CHUNK-1:0] chunk_s;
    logic             chunk_cout;
    logic [31:0]      wr_pos;
    logic             last_chunk;

    // Select the operand chunk addressed by the counter; result lands one bit up.
    assign chunk_a    = CHUNK'(opx_q >> (CHUNK * 32'(cnt_q)));
    assign chunk_b    = CHUNK'(opy_q >> (CHUNK * 32'(cnt_q)));
    assign wr_pos     = CHUNK * 32'(cnt_q) + 32'd1;
    assign last_chunk = (cnt_q == CW'(NCH - 1));

    cpa_chunk #(
        .N (CHUNK)
    ) u_cpa_chunk (
        .a    (chunk_a),
        .b    (chunk_b),
        .cin  (cy_q),
        .s    (chunk_s),
        .cout (chunk_cout)
    );

    // State and datapath registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cy_q        <= 1'b0;
            opx_q       <= '0;
            opy_q       <= '0;
            result_q    <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cy_q        <= cy_d;
            opx_q       <= opx_d;
            opy_q       <= opy_d;
            result_q    <= result_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    // Next-state and datapath update: accept, ripple chunks, hold until taken.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        cy_d        = cy_q;
        opx_d       = opx_q;
        opy_d       = opy_q;
        result_d    = result_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid && in_ready_q) begin
                    // sum bit 0 needs no add; the rest is shifted to align with carry.
                    opx_d      = {1'b0, sum_in[W-1:1]};
                    opy_d      = carry_in;
                    result_d   = {{(RW - 1){1'b0}}, sum_in[0]};
                    cnt_d      = '0;
                    cy_d       = 1'b0;
                    in_ready_d = 1'b0;
                    state_d    = ADD;
                end
            end
            ADD: begin
                result_d = (result_q & ~(CHUNK_MASK << wr_pos)) | (RW'(chunk_s) << wr_pos);
                cy_d     = chunk_cout;
                cnt_d    = cnt_q + CW'(1);
                if (last_chunk) begin
                    result_d[W+1] = chunk_cout;
                    cnt_d         = '0;
                    out_valid_d   = 1'b1;
                    state_d       = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign result    = result_q;

`ifdef CSA_RESOLVE_OVF_EN
    logic ovf_q;

    // Capture the two top result bits as they are formed on the last chunk.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if ((state_q == ADD) && last_chunk) begin
            ovf_q <= chunk_cout | chunk_s[CHUNK-1];
        end
    end

    assign out_ovf = ovf_q;
`else
    // No overflow flag in this build.
`endif

endmodule

// File: tb/tb_csa_carry_resolve.sv
// Self-checking bench for csa_carry_resolve (W=8, CHUNK=2).
module tb_csa_carry_resolve;

    localparam int unsigned W     = 8;
    localparam int unsigned CHUNK = 2;
    localparam int unsigned NCH   = W / CHUNK;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   sum_in;
    logic [W-1:0]   carry_in;
    logic           out_valid;
    logic           out_ready;
    logic [W+1:0]   result;
`ifdef CSA_RESOLVE_OVF_EN
    logic           out_ovf;
`endif

    int n_cmp  = 0;
    int n_fail = 0;

    csa_carry_resolve #(
        .W     (W),
        .CHUNK (CHUNK)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sum_in    (sum_in),
        .carry_in  (carry_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
`ifdef CSA_RESOLVE_OVF_EN
        ,
        .out_ovf   (out_ovf)
`endif
    );

    always #5 clk = ~clk;

    // Reference: plain integer arithmetic on the redundant pair.
    function automatic logic [W+1:0] ref_result(input logic [W-1:0] s, input logic [W-1:0] c);
        int unsigned v;
        v = int'(s) + 2 * int'(c);
        return (W + 2)'(v);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        sum_in    = W'($urandom);
        carry_in  = W'($urandom);
        repeat (3) tick();
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_in_ready got=%b exp=1", in_ready);
        end
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid);
        end
        n_cmp++;
        if (result !== '0) begin
            n_fail++; $display("FAIL reset_result got=%h exp=0", result);
        end
`ifdef CSA_RESOLVE_OVF_EN
        n_cmp++;
        if (out_ovf !== 1'b0) begin
            n_fail++; $display("FAIL reset_ovf got=%b exp=0", out_ovf);
        end
`endif
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        logic [W-1:0] ts [3];
        logic [W-1:0] tc [3];
        logic [W+1:0] exp_r;
        int           lat;
        ts[0] = 8'hFF; tc[0] = 8'hFF;
        ts[1] = 8'h00; tc[1] = 8'h80;
        ts[2] = 8'h7F; tc[2] = 8'h00;
        for (int k = 0; k < 3; k++) begin
            exp_r = ref_result(ts[k], tc[k]);
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_fail++; $display("FAIL dir%0d_idle_ready got=%b exp=1", k, in_ready);
            end
            out_ready = 1'b1;
            in_valid  = 1'b1;
            sum_in    = ts[k];
            carry_in  = tc[k];
            tick();
            in_valid = 1'b0;
            sum_in   = W'($urandom);
            carry_in = W'($urandom);
            lat = 0;
            while (out_valid !== 1'b1 && lat < 40) begin
                tick();
                lat++;
            end
            n_cmp++;
            if (lat != int'(NCH)) begin
                n_fail++; $display("FAIL dir%0d_latency got=%0d exp=%0d", k, lat, NCH);
            end
            n_cmp++;
            if (result !== exp_r) begin
                n_fail++; $display("FAIL dir%0d_result got=%h exp=%h", k, result, exp_r);
            end
`ifdef CSA_RESOLVE_OVF_EN
            n_cmp++;
            if (out_ovf !== (exp_r >= (W + 2)'(1 << W))) begin
                n_fail++; $display("FAIL dir%0d_ovf got=%b exp=%b", k, out_ovf, exp_r >= (W + 2)'(1 << W));
            end
`endif
            tick();
            n_cmp++;
            if (out_valid !== 1'b0) begin
                n_fail++; $display("FAIL dir%0d_single_xfer got=%b exp=0", k, out_valid);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [W+1:0] exp_r;
        int           lat;
        bit           bad;
        sum_in    = W'($urandom);
        carry_in  = W'($urandom);
        exp_r     = ref_result(sum_in, carry_in);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        tick();
        sum_in   = W'($urandom);
        carry_in = W'($urandom);
        lat = 0;
        while (out_valid !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        bad = (out_valid !== 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            if (out_valid !== 1'b1 || result !== exp_r || in_ready !== 1'b0) bad = 1'b1;
        end
        n_cmp++;
        if (bad) begin
            n_fail++;
            $display("FAIL bp_hold valid=%b ready=%b result=%h exp_valid=1 exp_ready=0 exp_result=%h",
                     out_valid, in_ready, result, exp_r);
        end
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_fail++; $display("FAIL bp_release valid=%b ready=%b exp_valid=0 exp_ready=1", out_valid, in_ready);
        end
        n_cmp++;
        if (result !== exp_r) begin
            n_fail++; $display("FAIL bp_result_kept got=%h exp=%h", result, exp_r);
        end
    endtask

    task automatic test_reset_mid_add();
        bit seen;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_in    = 8'hFF;
        carry_in  = 8'hFF;
        tick();
        in_valid = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== '0) begin
            n_fail++;
            $display("FAIL rst_mid_add ready=%b valid=%b result=%h exp 1/0/0", in_ready, out_valid, result);
        end
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid !== 1'b0) seen = 1'b1;
        end
        n_cmp++;
        if (seen) begin
            n_fail++; $display("FAIL rst_no_spurious got=out_valid_seen exp=none");
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] ps [2];
        logic [W-1:0] pc [2];
        logic [W+1:0] q [$];
        logic [W+1:0] got, e;
        int acc_cyc [2];
        int idx, recv, cyc;
        bit acc, xfer;
        ps[0] = 8'h01; pc[0] = 8'h01;
        ps[1] = 8'hAA; pc[1] = 8'h55;
        idx = 0; recv = 0; cyc = 0;
        acc_cyc[0] = 0; acc_cyc[1] = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        sum_in    = ps[0];
        carry_in  = pc[0];
        while (recv < 2 && cyc < 60) begin
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            got  = result;
            if (acc) begin
                q.push_back(ref_result(sum_in, carry_in));
                acc_cyc[idx] = cyc;
            end
            tick();
            cyc++;
            if (acc) begin
                idx++;
                if (idx < 2) begin
                    sum_in = ps[idx]; carry_in = pc[idx];
                end else begin
                    in_valid = 1'b0;
                end
            end
            if (xfer) begin
                e = q.pop_front();
                n_cmp++;
                if (got !== e) begin
                    n_fail++; $display("FAIL b2b_result%0d got=%h exp=%h", recv, got, e);
                end
                recv++;
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (recv != 2) begin
            n_fail++; $display("FAIL b2b_count got=%0d exp=2", recv);
        end
        n_cmp++;
        if (acc_cyc[1] - acc_cyc[0] != int'(NCH + 2)) begin
            n_fail++; $display("FAIL b2b_spacing got=%0d exp=%0d", acc_cyc[1] - acc_cyc[0], NCH + 2);
        end
    endtask

    task automatic test_random();
        logic [W+1:0] q [$];
        logic [W+1:0] got, held, e;
        int  sent, recv, cyc;
        bit  acc, xfer, hold_chk;
        sent = 0; recv = 0; cyc = 0; hold_chk = 1'b0; held = '0;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        while ((sent < 1000 || q.size() != 0) && cyc < 30000) begin
            acc  = in_valid && in_ready;
            xfer = out_valid && out_ready;
            got  = result;
            if (hold_chk) begin
                n_cmp++;
                if (out_valid !== 1'b1 || result !== held) begin
                    n_fail++; $display("FAIL rnd_hold valid=%b got=%h exp=%h", out_valid, result, held);
                end
            end
            if (out_valid && in_ready) begin
                n_cmp++; n_fail++;
                $display("FAIL rnd_ready_in_done got=1 exp=0");
            end
            hold_chk = out_valid && !out_ready;
            held     = result;
            if (xfer) begin
                n_cmp++;
                if (q.size() == 0) begin
                    n_fail++; $display("FAIL rnd_dup got=%h exp=no_transfer", got);
                end else begin
                    e = q.pop_front();
                    if (got !== e) begin
                        n_fail++; $display("FAIL rnd_result%0d got=%h exp=%h", recv, got, e);
                    end
                end
                recv++;
            end
            if (acc) begin
                q.push_back(ref_result(sum_in, carry_in));
                sent++;
            end
            tick();
            cyc++;
            out_ready = ($urandom_range(0, 1) == 1);
            if (acc || !in_valid) begin
                sum_in   = W'($urandom);
                carry_in = W'($urandom);
                in_valid = (sent < 1000) && ($urandom_range(0, 3) != 0);
            end
        end
        in_valid = 1'b0;
        n_cmp++;
        if (sent != 1000 || recv != 1000 || q.size() != 0) begin
            n_fail++;
            $display("FAIL rnd_totals sent=%0d recv=%0d pending=%0d exp 1000/1000/0", sent, recv, q.size());
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_mid_add();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
